// File: rtl/dodge_object_engine.sv
// Falling-obstacle engine: 10 slots, LFSR-placed spawns, per-frame motion and bottom retirement.
// One frame is a tick wait, a 10-cycle slot walk, a spawn cycle and a DONE strobe cycle.
module dodge_object_engine #(
  parameter int TICK_CYCLES = 833333,
  parameter int SPAWN_TICKS = 30,
  parameter int SPEED       = 2,
  parameter int Y_LIMIT     = 224
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         startgame,
  input  logic         gameover,
  output logic [179:0] objCoordcomb,
  output logic         imagedone,
  output logic         running,
  output logic [15:0]  score
);

  localparam int          NSLOT      = 10;
  localparam logic [31:0] TICK_LAST  = 32'(TICK_CYCLES - 1);
  localparam logic [15:0] SPAWN_LAST = 16'(SPAWN_TICKS - 1);
  localparam logic [8:0]  SPEED_9    = 9'(SPEED);
  localparam logic [8:0]  Y_LIMIT_9  = 9'(Y_LIMIT);
  localparam logic [8:0]  X_MAX      = 9'd304;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    UPDATE    = 3'd2,
    SPAWN     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [31:0]                 r_tick_cnt;
  logic [3:0]                  r_slot_idx;
  logic [15:0]                 r_spawn_cnt;
  logic [15:0]                 r_lfsr;
  logic [15:0]                 r_score;
  logic [NSLOT-1:0][17:0]      r_slot;

  logic                        w_abort;
  logic                        w_tick_end;
  logic [15:0]                 w_lfsr_nxt;
  logic [8:0]                  w_rnd;
  logic [8:0]                  w_sx;
  logic [17:0]                 w_cur;
  logic [8:0]                  w_ny;
  logic                        w_retire;
  logic                        w_free_vld;
  logic [3:0]                  w_free_idx;

  // gameover only matters while a game is in progress
  assign w_abort    = gameover && (r_state != IDLE);
  assign w_tick_end = (r_tick_cnt == TICK_LAST);
  assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  // Fold x values past the right edge back by 256 so a 16-px object stays on screen
  assign w_rnd = r_lfsr[8:0];
  assign w_sx  = (w_rnd > X_MAX) ? (w_rnd - 9'd256) : w_rnd;

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (r_slot_idx == 4'(i)) w_cur = r_slot[i];
    end
  end

  assign w_ny     = {1'b0, w_cur[16:9]} + SPEED_9;
  assign w_retire = w_cur[17] && (w_ny > Y_LIMIT_9);

  always_comb begin
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!r_slot[i][17]) begin
        w_free_vld = 1'b1;
        w_free_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    imagedone   = 1'b0;
    running     = (r_state != IDLE);
    case (r_state)
      IDLE:      if (startgame) w_state_nxt = WAIT_TICK;
      WAIT_TICK: if (w_tick_end) w_state_nxt = UPDATE;
      UPDATE:    if (r_slot_idx == 4'(NSLOT - 1)) w_state_nxt = SPAWN;
      SPAWN:     w_state_nxt = DONE;
      DONE: begin
        w_state_nxt = WAIT_TICK;
        imagedone   = !gameover;
      end
      default:   w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_tick_cnt  <= '0;
      r_slot_idx  <= '0;
      r_spawn_cnt <= '0;
      r_lfsr      <= LFSR_SEED;
      r_score     <= '0;
      r_slot      <= '0;
    end else if (w_abort) begin
      r_tick_cnt <= '0;
      r_slot_idx <= '0;
      r_slot     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (startgame) begin
            r_score     <= '0;
            r_spawn_cnt <= '0;
            r_tick_cnt  <= '0;
            r_slot_idx  <= '0;
            r_slot      <= '0;
          end
        end
        WAIT_TICK: begin
          if (w_tick_end) begin
            r_tick_cnt <= '0;
            r_slot_idx <= '0;
            r_lfsr     <= w_lfsr_nxt;
          end else begin
            r_tick_cnt <= r_tick_cnt + 32'd1;
          end
        end
        UPDATE: begin
          r_slot_idx <= r_slot_idx + 4'd1;
          for (int i = 0; i < NSLOT; i++) begin
            if ((r_slot_idx == 4'(i)) && w_cur[17]) begin
              r_slot[i] <= w_retire ? 18'd0 : {1'b1, w_ny[7:0], w_cur[8:0]};
            end
          end
          if (w_retire && (r_score != 16'hFFFF)) r_score <= r_score + 16'd1;
        end
        SPAWN: begin
          // A full playfield silently drops the spawn but still restarts the interval
          if (r_spawn_cnt == SPAWN_LAST) begin
            r_spawn_cnt <= '0;
            for (int i = 0; i < NSLOT; i++) begin
              if (w_free_vld && (w_free_idx == 4'(i))) r_slot[i] <= {1'b1, 8'd0, w_sx};
            end
          end else begin
            r_spawn_cnt <= r_spawn_cnt + 16'd1;
          end
        end
        DONE:    r_tick_cnt <= '0;
        default: r_tick_cnt <= '0;
      endcase
    end
  end

  assign objCoordcomb = r_slot;
  assign score        = r_score;

endmodule

// File: tb/tb_dodge_object_engine.sv
// Bench for dodge_object_engine: a frame-level model queues expected coordinates and score,
// directed steps cover spawn, retirement, full slots, gameover, async reset and saturation.
module tb_dodge_object_engine;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         startgame;
  logic         gameover;
  logic [179:0] objCoordcomb;
  logic         imagedone;
  logic         running;
  logic [15:0]  score;

  dodge_object_engine #(
    .TICK_CYCLES(4),
    .SPAWN_TICKS(2),
    .SPEED(2),
    .Y_LIMIT(224)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .startgame(startgame),
    .gameover(gameover),
    .objCoordcomb(objCoordcomb),
    .imagedone(imagedone),
    .running(running),
    .score(score)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [179:0] coord;
    logic [15:0]  score;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [17:0] m_slot [10];
  logic [15:0] m_lfsr;
  logic [15:0] m_score;
  int          m_spawn;

  task automatic chk(input string tag, input logic [179:0] obs, input logic [179:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_start();
    for (int i = 0; i < 10; i++) m_slot[i] = '0;
    m_score = '0;
    m_spawn = 0;
  endtask

  task automatic model_lfsr_step();
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  function automatic logic [179:0] model_pack();
    logic [179:0] v = '0;
    for (int i = 0; i < 10; i++) v[18*i +: 18] = m_slot[i];
    return v;
  endfunction

  function automatic int count_active(input logic [179:0] v);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[18*i+17]);
    return n;
  endfunction

  task automatic model_tick();
    logic [8:0] ny;
    logic [8:0] r;
    logic [8:0] sx;
    int         fr;
    exp_t       e;
    model_lfsr_step();
    for (int i = 0; i < 10; i++) begin
      if (m_slot[i][17]) begin
        ny = {1'b0, m_slot[i][16:9]} + 9'd2;
        if (ny > 9'd224) begin
          m_slot[i] = '0;
          if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
        end else begin
          m_slot[i][16:9] = ny[7:0];
        end
      end
    end
    if (m_spawn == 1) begin
      fr = -1;
      for (int i = 9; i >= 0; i--) if (!m_slot[i][17]) fr = i;
      r  = m_lfsr[8:0];
      sx = (r > 9'd304) ? r - 9'd256 : r;
      if (fr >= 0) m_slot[fr] = {1'b1, 8'd0, sx};
      m_spawn = 0;
    end else begin
      m_spawn++;
    end
    e.coord = model_pack();
    e.score = m_score;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 64) begin
      @(negedge CLOCK_50);
      cyc++;
      ok = imagedone;
    end
  endtask

  task automatic check_frame(input string tag, output int cyc);
    exp_t e;
    bit   ok;
    model_tick();
    wait_done(ok, cyc);
    e = exp_q.pop_front();
    chk({tag, "_done"}, 180'(ok), 180'(1));
    if (ok) begin
      chk({tag, "_coord"}, objCoordcomb, e.coord);
      chk({tag, "_score"}, 180'(score), 180'(e.score));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int hits;
    reset     = 1'b0;
    startgame = 1'b0;
    gameover  = 1'b0;
    m_lfsr    = 16'hACE1;
    model_start();
    repeat (2) @(negedge CLOCK_50);
    chk("rst_coord", objCoordcomb, '0);
    chk("rst_imagedone", 180'(imagedone), '0);
    chk("rst_running", 180'(running), '0);
    chk("rst_score", 180'(score), '0);
    reset = 1'b1;
    @(negedge CLOCK_50);

    startgame = 1'b1;
    @(negedge CLOCK_50);
    startgame = 1'b0;
    for (int t = 1; t <= 114; t++) begin
      check_frame($sformatf("tick%0d", t), cyc);
      if (t == 1) begin
        chk("tick1_running", 180'(running), 180'(1));
        chk("tick1_nospawn", objCoordcomb, '0);
      end
      if (t == 2 || t == 3) chk($sformatf("period%0d", t), 180'(cyc), 180'(16));
      if (t == 2) begin
        chk("tick2_slot0", 180'(objCoordcomb[17:0]), 180'({1'b1, 8'd0, 9'd56}));
        chk("tick2_rest", 180'(objCoordcomb[179:18]), '0);
      end
      if (t == 20 || t == 22) chk($sformatf("full%0d", t), 180'(count_active(objCoordcomb)), 180'(10));
    end

    // Tick 115: slot 0 retires during UPDATE index 0
    repeat (5) @(negedge CLOCK_50);
    chk("t115_pre_slot0", 180'(objCoordcomb[17:0]), 180'({1'b1, 8'd224, 9'd56}));
    chk("t115_pre_score", 180'(score), '0);
    @(negedge CLOCK_50);
    chk("t115_slot0_clear", 180'(objCoordcomb[17:0]), '0);
    chk("t115_score", 180'(score), 180'(1));
    check_frame("tick115", cyc);
    check_frame("tick116", cyc);

    force dut.r_score = 16'hFFFF;
    m_score = 16'hFFFF;
    @(negedge CLOCK_50);
    release dut.r_score;
    check_frame("tick117", cyc);
    chk("score_sat", 180'(score), 180'(16'hFFFF));

    // gameover in the middle of the slot walk
    repeat (7) @(negedge CLOCK_50);
    gameover = 1'b1;
    @(negedge CLOCK_50);
    chk("go_coord", objCoordcomb, '0);
    chk("go_running", 180'(running), '0);
    chk("go_score", 180'(score), 180'(16'hFFFF));
    chk("go_imagedone", 180'(imagedone), '0);
    gameover = 1'b0;
    model_lfsr_step();
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (imagedone) hits++;
    end
    chk("go_no_done", 180'(hits), '0);
    chk("go_idle", 180'(running), '0);

    model_start();
    startgame = 1'b1;
    @(negedge CLOCK_50);
    startgame = 1'b0;
    for (int t = 1; t <= 3; t++) check_frame($sformatf("restart%0d", t), cyc);

    // Asynchronous reset in the middle of the slot walk
    repeat (7) @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    chk("rst2_coord", objCoordcomb, '0);
    chk("rst2_running", 180'(running), '0);
    chk("rst2_imagedone", 180'(imagedone), '0);
    chk("rst2_score", 180'(score), '0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    m_lfsr = 16'hACE1;
    model_start();
    startgame = 1'b1;
    @(negedge CLOCK_50);
    startgame = 1'b0;
    check_frame("reseed1", cyc);
    check_frame("reseed2", cyc);
    chk("reseed_x56", 180'(objCoordcomb[17:0]), 180'({1'b1, 8'd0, 9'd56}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dodge_object_engine.md
# dodge_object_engine

Generates and animates the falling obstacles of the dodge-ball game and publishes their packed coordinates to the sketch/render stage. It holds 10 object slots, spawns objects at pseudo-random x positions, moves active objects down once per frame tick, retires objects that pass the bottom (counting them as dodged), and pulses `imagedone` once per frame when the coordinate set is complete. It sits directly upstream of the renderer and collision detector, which consume `objCoordcomb`, and it returns to idle on `gameover`.

## Interface
- `TICK_CYCLES`, default 833333: CLOCK_50 cycles spent waiting per frame, about 60 Hz.
- `SPAWN_TICKS`, default 30: number of frame ticks between spawn attempts.
- `SPEED`, default 2: pixels an object moves down per tick.
- `Y_LIMIT`, default 224: the largest y an object may occupy and remain active.
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `startgame`  in  1  level; when sampled high in IDLE, the game starts.
- `gameover`  in  1  level; stops the game and clears all slots.
- `objCoordcomb`  out  180  registered. Slot i occupies [18i+17 : 18i]: bit 18i+17 = active, [18i+16 : 18i+9] = y (8b), [18i+8 : 18i] = x (9b).
- `imagedone`  out  1  one-cycle pulse; all slots are updated for this frame.
- `running`  out  1  high whenever the state is not IDLE.
- `score`  out  16  number of objects retired at the bottom; saturates at 16'hFFFF.

## Operation
- States: IDLE, WAIT_TICK, UPDATE, SPAWN, DONE.
- IDLE: if `startgame`=1, clear `score`, clear all slots, set spawn counter to 0, go to WAIT_TICK. `score` is otherwise held.
- WAIT_TICK: the tick counter counts from 0 to TICK_CYCLES-1, then goes to UPDATE. The counter is cleared on entry.
- On entry to UPDATE, the LFSR advances once, so it advances exactly once per tick.
- UPDATE: processes one slot per cycle, index 0 to 9.
  - Inactive slot: unchanged.
  - Active slot: ny = y + SPEED, computed 9 bits wide.
    - ny > Y_LIMIT: slot cleared to 18'b0, `score` += 1 (saturating).
    - Otherwise: y = ny[7:0].
  - After index 9, go to SPAWN.
- SPAWN:
  - If spawn counter = SPAWN_TICKS-1, the lowest-index inactive slot is loaded with active=1, y=0, x=sx, and the counter is reset to 0.
  - If no slot is free, the spawn is dropped silently and the counter is still reset to 0.
  - Otherwise the counter increments.
  - Go to DONE.
- DONE: `imagedone`=1 for this single cycle, then go to WAIT_TICK.
- LFSR: 16-bit Fibonacci, seed 16'hACE1.
  - b = l[0]^l[2]^l[3]^l[5]; l = {b, l[15:1]}.
- Spawn x: r = l[8:0]; sx = (r > 304) ? r - 256 : r. This keeps x ≤ 304, so a 16-px object stays on the 320-px screen.
- `gameover`=1 in any non-IDLE state takes precedence over all other actions.
  - Next cycle: all slots are 0, state is IDLE, `imagedone`=0.
  - `score` keeps its value.
  - The LFSR is not reseeded.

## Timing
- Reset values: `objCoordcomb`=0, `imagedone`=0, `running`=0, `score`=0, state IDLE, LFSR=16'hACE1, all counters 0.
- Reset is asynchronous and may occur mid-frame; all of the above values apply immediately.
- The start decision occurs in the cycle `startgame` is sampled high; WAIT_TICK is the state on the next cycle.
- Frame period = TICK_CYCLES + 12 cycles: TICK_CYCLES wait, 10 update, 1 spawn, 1 DONE.
- Slot i's update is visible on `objCoordcomb` on the cycle after UPDATE index i. The spawned slot is visible on the cycle after SPAWN.
- All slots are therefore stable and final for the frame when `imagedone` is high.
- The `score` increment for a retired slot is visible on the same cycle as the cleared slot.
- `gameover` asserted in the same cycle as DONE: no `imagedone` pulse is produced.
- `startgame` held high after gameover restarts the game from IDLE on the following cycle.

## Test plan
Bench parameters: TICK_CYCLES=4, SPAWN_TICKS=2, SPEED=2, Y_LIMIT=224.
- **Reset, then `startgame` pulse:** `imagedone` pulses every 16 cycles. Tick 1 produces no spawn. At tick 2's `imagedone`, slot 0 = {1, y=0, x=56} (LFSR=16'hAB38, r=312 → 56); all other slots are 0.
- **Motion and retirement:** slot 0 has y=2k at tick 2+k. At tick 115 slot 0 is cleared and `score` becomes 1 on the same cycle.
- **Slots full:** spawns occur at ticks 2, 4, ..., 20, and all 10 active bits are set after tick 20. The tick-22 spawn is dropped: active count stays 10, and no slot x/y changes other than motion.
- **`gameover` mid-UPDATE:** on the next cycle all 180 bits are 0, `running`=0, `score` is unchanged, and no `imagedone` occurs until restart.
- **Reset asserted mid-UPDATE:** all outputs return to 0 immediately. After release plus `startgame`, the first spawned x is 56 again.
- **`score` preset to 16'hFFFF, then another retirement:** `score` stays at 16'hFFFF.
